// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory read port, hazard/redirect controls
// and the IF/ID register outputs, seen from the fetch unit (master).
interface inst_fetch_unit_if #(
  parameter int PC_W   = 16,
  parameter int INST_W = 16
);
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic              mem_busy;
  logic              stall;
  logic              branch_valid;
  logic [PC_W-1:0]   branch_target;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;

  modport master (
    output pc, if_pc, if_inst, if_valid,
    input  inst, mem_busy, stall, branch_valid, branch_target
  );

  modport slave (
    input  pc, if_pc, if_inst, if_valid,
    output inst, mem_busy, stall, branch_valid, branch_target
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// IF stage: owns the PC, fetches one instruction per cycle from a combinational
// instruction memory, and buffers one fetch in a skid entry while ID is stalled.
module inst_fetch_unit #(
  parameter int                PC_W     = 16,
  parameter int                INST_W   = 16,
  parameter logic [PC_W-1:0]   START_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_unit_if.master  bus
);

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_e;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
    return a + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

  skid_state_e       r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc_p0, w_pc_nxt;
  logic [PC_W-1:0]   r_skid_pc_p0;
  logic [INST_W-1:0] r_skid_inst_p0;
  logic              w_skid_ld;
  logic [PC_W-1:0]   r_if_pc_p1, w_if_pc_nxt;
  logic [INST_W-1:0] r_if_inst_p1, w_if_inst_nxt;
  logic              r_vld_p1, w_vld_nxt;
  logic              w_fetch_ok;

  // A fetch only counts when the memory port is ours and no redirect kills it.
  assign w_fetch_ok = !bus.mem_busy && !bus.branch_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc_p0;
    w_skid_ld     = 1'b0;
    w_if_pc_nxt   = r_if_pc_p1;
    w_if_inst_nxt = r_if_inst_p1;
    w_vld_nxt     = r_vld_p1;

    if (bus.branch_valid) begin
      w_pc_nxt      = bus.branch_target;
      w_if_pc_nxt   = bus.branch_target;
      w_if_inst_nxt = NOP_INST;
      w_vld_nxt     = 1'b0;
      w_state_nxt   = SKID_EMPTY;
    end else if (bus.stall) begin
      if (r_state == SKID_EMPTY && w_fetch_ok) begin
        w_skid_ld   = 1'b1;
        w_pc_nxt    = pc_inc(r_pc_p0);
        w_state_nxt = SKID_FULL;
      end
    end else if (r_state == SKID_FULL) begin
      // Skid entry is older than the current fetch, so it drains first.
      w_if_pc_nxt   = r_skid_pc_p0;
      w_if_inst_nxt = r_skid_inst_p0;
      w_vld_nxt     = 1'b1;
      if (w_fetch_ok) begin
        w_skid_ld = 1'b1;
        w_pc_nxt  = pc_inc(r_pc_p0);
      end else begin
        w_state_nxt = SKID_EMPTY;
      end
    end else begin
      if (w_fetch_ok) begin
        w_if_pc_nxt   = r_pc_p0;
        w_if_inst_nxt = bus.inst;
        w_vld_nxt     = 1'b1;
        w_pc_nxt      = pc_inc(r_pc_p0);
      end else begin
        w_if_inst_nxt = NOP_INST;
        w_vld_nxt     = 1'b0;
      end
    end
  end

  // ---- stage p0: PC and skid control ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SKID_EMPTY;
      r_pc_p0 <= START_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc_p0 <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_skid_ld) begin
      r_skid_pc_p0   <= r_pc_p0;
      r_skid_inst_p0 <= bus.inst;
    end
  end

  // ---- stage p1: IF/ID register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_pc_p1   <= '0;
      r_if_inst_p1 <= NOP_INST;
      r_vld_p1     <= 1'b0;
    end else begin
      r_if_pc_p1   <= w_if_pc_nxt;
      r_if_inst_p1 <= w_if_inst_nxt;
      r_vld_p1     <= w_vld_nxt;
    end
  end

  assign bus.pc       = r_pc_p0;
  assign bus.if_pc    = r_if_pc_p1;
  assign bus.if_inst  = r_if_inst_p1;
  assign bus.if_valid = r_vld_p1;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed vector table plus a mid-run reset and a random stall/mem_busy
// scoreboard for inst_fetch_unit; memory word n holds 16'h6800+n.
module tb_inst_fetch_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  inst_fetch_unit_if #(.PC_W(16), .INST_W(16)) bus ();

  inst_fetch_unit #(
    .PC_W(16), .INST_W(16), .START_PC(16'h0000), .NOP_INST(16'h0800)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.inst = 16'h6800 + bus.pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        mb;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic [15:0] e_ifpc;
    logic [15:0] e_inst;
    logic        e_vld;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(input logic st, input logic mb, input logic br,
                              input logic [15:0] tgt, input logic [15:0] e_pc,
                              input logic [15:0] e_ifpc, input logic [15:0] e_inst,
                              input logic e_vld);
    vec_t v;
    v.st = st; v.mb = mb; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_inst = e_inst; v.e_vld = e_vld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input logic st, input logic mb, input logic br, input logic [15:0] tgt);
    bus.stall         = st;
    bus.mem_busy      = mb;
    bus.branch_valid  = br;
    bus.branch_target = tgt;
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] h_pc, h_inst;
    logic        h_vld;
    logic        st, mb;
    n_checks = 0;
    n_errors = 0;

    //          st mb br tgt       pc        if_pc     if_inst   vld
    vt[0]  = mk(0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 16'h6800, 1);
    vt[1]  = mk(0, 0, 0, 16'h0000, 16'h0002, 16'h0001, 16'h6801, 1);
    vt[2]  = mk(0, 0, 0, 16'h0000, 16'h0003, 16'h0002, 16'h6802, 1);
    vt[3]  = mk(1, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'h6802, 1);
    vt[4]  = mk(1, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'h6802, 1);
    vt[5]  = mk(1, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'h6802, 1);
    vt[6]  = mk(0, 0, 0, 16'h0000, 16'h0005, 16'h0003, 16'h6803, 1);
    vt[7]  = mk(0, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h6804, 1);
    vt[8]  = mk(0, 0, 0, 16'h0000, 16'h0007, 16'h0005, 16'h6805, 1);
    vt[9]  = mk(0, 1, 0, 16'h0000, 16'h0007, 16'h0006, 16'h6806, 1);
    vt[10] = mk(0, 1, 0, 16'h0000, 16'h0007, 16'h0006, 16'h0800, 0);
    vt[11] = mk(0, 0, 0, 16'h0000, 16'h0008, 16'h0007, 16'h6807, 1);
    vt[12] = mk(0, 0, 0, 16'h0000, 16'h0009, 16'h0008, 16'h6808, 1);
    vt[13] = mk(1, 1, 0, 16'h0000, 16'h0009, 16'h0008, 16'h6808, 1);
    vt[14] = mk(1, 0, 0, 16'h0000, 16'h000A, 16'h0008, 16'h6808, 1);
    vt[15] = mk(1, 0, 1, 16'h0040, 16'h0040, 16'h0040, 16'h0800, 0);
    vt[16] = mk(0, 0, 0, 16'h0000, 16'h0041, 16'h0040, 16'h6840, 1);
    vt[17] = mk(0, 0, 1, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'h0800, 0);
    vt[18] = mk(0, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFE, 16'h67FE, 1);
    vt[19] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 16'h67FF, 1);
    vt[20] = mk(0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 16'h6800, 1);
    vt[21] = mk(0, 0, 0, 16'h0000, 16'h0002, 16'h0001, 16'h6801, 1);
    vt[22] = mk(1, 0, 0, 16'h0000, 16'h0003, 16'h0001, 16'h6801, 1);
    vt[23] = mk(1, 1, 0, 16'h0000, 16'h0003, 16'h0001, 16'h6801, 1);
    vt[24] = mk(0, 1, 0, 16'h0000, 16'h0003, 16'h0002, 16'h6802, 1);
    vt[25] = mk(0, 0, 0, 16'h0000, 16'h0004, 16'h0003, 16'h6803, 1);
    vt[26] = mk(0, 1, 1, 16'h0100, 16'h0100, 16'h0100, 16'h0800, 0);
    vt[27] = mk(0, 0, 0, 16'h0000, 16'h0101, 16'h0100, 16'h6900, 1);

    rst = 1'b0;
    drive(0, 0, 0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc",       32'(bus.pc),       32'h0000);
    chk("reset_if_pc",    32'(bus.if_pc),    32'h0000);
    chk("reset_if_inst",  32'(bus.if_inst),  32'h0800);
    chk("reset_if_valid", 32'(bus.if_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(vt[i].st, vt[i].mb, vt[i].br, vt[i].tgt);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pc", i),       32'(bus.pc),       32'(vt[i].e_pc));
      chk($sformatf("vec%0d_if_pc", i),    32'(bus.if_pc),    32'(vt[i].e_ifpc));
      chk($sformatf("vec%0d_if_inst", i),  32'(bus.if_inst),  32'(vt[i].e_inst));
      chk($sformatf("vec%0d_if_valid", i), 32'(bus.if_valid), 32'(vt[i].e_vld));
    end

    // Mid-run asynchronous reset: effect must be visible before any edge.
    drive(1, 0, 0, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_pc",       32'(bus.pc),       32'h0000);
    chk("async_rst_if_inst",  32'(bus.if_inst),  32'h0800);
    chk("async_rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("async_rst_if_pc",    32'(bus.if_pc),    32'h0000);
    drive(0, 0, 0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Reset must also have flushed the skid: first delivery is address 0.
    @(posedge clk);
    #1;
    chk("post_rst_if_pc",    32'(bus.if_pc),    32'h0000);
    chk("post_rst_if_valid", 32'(bus.if_valid), 32'h1);
    exp_pc = 16'h0001;

    for (int c = 0; c < 1000; c++) begin
      st = ($urandom_range(0, 9) < 3);
      mb = ($urandom_range(0, 9) < 3);
      h_pc   = bus.if_pc;
      h_inst = bus.if_inst;
      h_vld  = bus.if_valid;
      drive(st, mb, 0, 16'h0000);
      @(posedge clk);
      #1;
      if (st) begin
        if (bus.if_pc !== h_pc || bus.if_inst !== h_inst || bus.if_valid !== h_vld) begin
          chk($sformatf("rnd%0d_stall_hold", c),
              {bus.if_pc, bus.if_inst}, {h_pc, h_inst});
          chk($sformatf("rnd%0d_stall_hold_vld", c), 32'(bus.if_valid), 32'(h_vld));
        end else begin
          n_checks++;
        end
      end else if (bus.if_valid) begin
        chk($sformatf("rnd%0d_if_pc", c),   32'(bus.if_pc),   32'(exp_pc));
        chk($sformatf("rnd%0d_if_inst", c), 32'(bus.if_inst), 32'(16'h6800 + exp_pc));
        exp_pc = bus.if_pc + 16'h0001;
      end else begin
        chk($sformatf("rnd%0d_bubble_inst", c), 32'(bus.if_inst), 32'h0800);
      end
    end
    chk("rnd_progress", 32'(exp_pc > 16'd200), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- IF-stage initiator of the instruction-memory read interface: drives the fetch address and samples the returned 16-bit instruction.
- The instruction memory returns `inst` combinationally, in the same cycle as `pc`.
- Owns the PC register, sequential increment, branch redirect, a one-entry skid buffer and the IF/ID output register.
- Yields the shared memory port to data accesses (LW/SW) when `mem_busy` is asserted.

Parameters:
- PC_W, 16, width of PC and fetch address.
- INST_W, 16, instruction width.
- START_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0800, instruction emitted for bubbles and after reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- pc  out  PC_W  fetch address to instruction memory; equals the PC register.
- inst  in  INST_W  instruction returned for `pc`, same cycle.
- mem_busy  in  1  data access owns the memory this cycle; `inst` is invalid.
- stall  in  1  hazard unit: hold the IF/ID outputs.
- branch_valid  in  1  redirect request from ID/EX.
- branch_target  in  PC_W  redirect address.
- if_pc  out  PC_W  address of the instruction in IF/ID.
- if_inst  out  INST_W  instruction in IF/ID.
- if_valid  out  1  if_inst is a real instruction, not a bubble.

Behaviour:
- Reset (rst=0, asynchronous): PC=START_PC, if_pc=0, if_inst=NOP_INST, if_valid=0, skid buffer EMPTY. Reset mid-operation discards the skid contents and any pending redirect.
- A fetch completes in a cycle iff mem_busy=0 and branch_valid=0; the completed fetch is the pair (pc, inst).
- Skid states: EMPTY and FULL. FULL holds skid_pc/skid_inst.
- Per-edge priority: branch_valid > stall > mem_busy.
- branch_valid=1, regardless of stall or mem_busy:
  - PC<=branch_target.
  - if_valid<=0, if_inst<=NOP_INST, if_pc<=branch_target.
  - skid->EMPTY; the current fetch is discarded.
- stall=1, branch_valid=0:
  - IF/ID outputs hold.
  - Skid EMPTY and fetch completes: capture into skid, PC<=PC+1, skid->FULL.
  - Skid FULL, or mem_busy=1: PC holds, nothing captured.
- stall=0, branch_valid=0, skid FULL:
  - Outputs <= skid contents, if_valid<=1.
  - Fetch completes: skid<=(pc, inst), PC<=PC+1, stays FULL.
  - mem_busy=1: skid->EMPTY, PC holds.
- stall=0, branch_valid=0, skid EMPTY:
  - Fetch completes: outputs<=(pc, inst), if_valid<=1, PC<=PC+1.
  - mem_busy=1: bubble (if_valid<=0, if_inst<=NOP_INST, if_pc holds), PC holds.
- PC increment is modulo 2^PC_W: 16'hFFFF+1 = 16'h0000, with no flag.
- Latency: the instruction at address A appears on if_inst one cycle after pc=A with no stall. In steady state, one instruction is delivered per cycle.
- Ordering: instructions exit in address order. None is lost or duplicated across any stall/mem_busy combination without a branch.
- Simultaneous stall=1 and mem_busy=1: PC and outputs hold, skid unchanged.

Test Plan:
- Reset release with memory word n = 16'h6800+n, no stall: if_pc 0,1,2,3 on successive cycles with matching if_inst, if_valid=1 from the first edge. Asserting rst low mid-run immediately gives if_valid=0, if_inst=16'h0800, pc=0.
- stall=1 for 3 cycles at if_pc=2: outputs hold 2, pc advances once to 4 and then holds (skid FULL with 3). After release: if_pc 3,4,5 consecutively, no gaps or duplicates.
- mem_busy=1 for 1 cycle while skid EMPTY: one bubble (if_valid=0, if_inst=16'h0800), pc holds. The next cycle delivers the held address.
- branch_valid=1 with target 16'h0040 while stall=1 and skid FULL: next cycle if_valid=0, skid EMPTY, pc=16'h0040. The following cycle if_pc=16'h0040, if_valid=1.
- Wrap: branch to 16'hFFFE, run freely: if_pc sequence FFFE, FFFF, 0000, 0001.
- Random stall/mem_busy (no branches) for 1000 cycles against a scoreboard: the valid if_pc stream is strictly consecutive.
